// File: rtl/search_arbiter.sv
// search_arbiter
//
// Round-robin front end that shares one binary_search unit among N_REQ
// requesters. A granted requester's key is latched onto bs_a, the unit is
// started, and the arbiter waits for bs_done or a watchdog timeout. The result
// goes back to the granted requester as a one-cycle resp_valid strobe. A
// one-cycle bs_reset pulse then clears the search unit before the next grant.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   req         level request per requester
//   req_a       packed keys, requester i at [i*DATA_W +: DATA_W]
//   resp_valid  one-hot response strobe (one cycle)
//   resp_found  search hit, valid with resp_valid and held until next response
//   resp_loc    hit address, 0 on miss or error, held until next response
//   resp_err    watchdog timeout, held until next response
//   busy        high while a search is running or being released
//   bs_start    search unit start, held for the whole search
//   bs_a        search unit key, frozen for the whole search
//   bs_reset    one-cycle synchronous clear to the search unit
//   bs_done     search unit done
//   bs_found    search unit hit flag
//   bs_loc      search unit hit address
module search_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 48
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  output logic [N_REQ-1:0]          resp_valid,
  output logic                      resp_found,
  output logic [ADDR_W-1:0]         resp_loc,
  output logic                      resp_err,
  output logic                      busy,
  output logic                      bs_start,
  output logic [DATA_W-1:0]         bs_a,
  output logic                      bs_reset,
  input  logic                      bs_done,
  input  logic                      bs_found,
  input  logic [ADDR_W-1:0]         bs_loc
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StRelease} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       cur_q, cur_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_W-1:0]     bs_a_q, bs_a_d;
  logic                  bs_start_q, bs_start_d;
  logic                  bs_reset_q, bs_reset_d;
  logic                  busy_q, busy_d;
  logic [N_REQ-1:0]      resp_valid_q, resp_valid_d;
  logic                  resp_found_q, resp_found_d;
  logic [ADDR_W-1:0]     resp_loc_q, resp_loc_d;
  logic                  resp_err_q, resp_err_d;

  // Round-robin pick: lowest requester above last wins; otherwise wrap to
  // the lowest requester overall.
  logic [N_REQ-1:0]      upper_mask;
  logic [N_REQ-1:0]      req_hi;
  logic [IdxW-1:0]       grant_idx;
  logic [DATA_W-1:0]     grant_key;

  always_comb begin
    upper_mask = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      upper_mask[i] = (IdxW'(i) > last_q);
    end
    req_hi    = req & upper_mask;
    grant_idx = '0;
    // Scan downward so the lowest set bit is the one left standing.
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req[i]) grant_idx = IdxW'(i);
    end
    if (|req_hi) begin
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
        if (req_hi[i]) grant_idx = IdxW'(i);
      end
    end
    grant_key = req_a[grant_idx*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    bs_a_d       = bs_a_q;
    bs_start_d   = bs_start_q;
    bs_reset_d   = 1'b0;
    busy_d       = busy_q;
    resp_valid_d = '0;
    resp_found_d = resp_found_q;
    resp_loc_d   = resp_loc_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      StIdle: begin
        bs_start_d = 1'b0;
        busy_d     = 1'b0;
        if (|req) begin
          cur_d      = grant_idx;
          last_d     = grant_idx;
          bs_a_d     = grant_key;
          bs_start_d = 1'b1;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = StRun;
        end
      end

      StRun: begin
        // Done is checked first so it wins over a coincident timeout.
        if (bs_done) begin
          resp_found_d        = bs_found;
          resp_loc_d          = bs_found ? bs_loc : '0;
          resp_err_d          = 1'b0;
          resp_valid_d[cur_q] = 1'b1;
          bs_start_d          = 1'b0;
          bs_reset_d          = 1'b1;
          state_d             = StRelease;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          resp_found_d        = 1'b0;
          resp_loc_d          = '0;
          resp_err_d          = 1'b1;
          resp_valid_d[cur_q] = 1'b1;
          bs_start_d          = 1'b0;
          bs_reset_d          = 1'b1;
          state_d             = StRelease;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StRelease: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cur_q        <= '0;
      last_q       <= IdxW'(N_REQ - 1);
      cnt_q        <= '0;
      bs_a_q       <= '0;
      bs_start_q   <= 1'b0;
      bs_reset_q   <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= '0;
      resp_found_q <= 1'b0;
      resp_loc_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      bs_a_q       <= bs_a_d;
      bs_start_q   <= bs_start_d;
      bs_reset_q   <= bs_reset_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_found_q <= resp_found_d;
      resp_loc_q   <= resp_loc_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_found = resp_found_q;
  assign resp_loc   = resp_loc_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign bs_start   = bs_start_q;
  assign bs_a       = bs_a_q;
  assign bs_reset   = bs_reset_q;

endmodule

// File: tb/tb_search_arbiter.sv
// tb_search_arbiter
//
// Drives search_arbiter against a behavioural search unit (32-entry RAM,
// mem[i] = 2*i) with directed and random requests. Expected grants, results
// and latencies come from a reference model of the arbitration rules.
module tb_search_arbiter;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned TIMEOUT = 48;
  localparam int          HANG    = 1000;

  logic                    clk;
  logic                    reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ-1:0]        resp_valid;
  logic                    resp_found;
  logic [ADDR_W-1:0]       resp_loc;
  logic                    resp_err;
  logic                    busy;
  logic                    bs_start;
  logic [DATA_W-1:0]       bs_a;
  logic                    bs_reset;
  logic                    bs_done;
  logic                    bs_found;
  logic [ADDR_W-1:0]       bs_loc;

  search_arbiter #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_a     (req_a),
    .resp_valid(resp_valid),
    .resp_found(resp_found),
    .resp_loc  (resp_loc),
    .resp_err  (resp_err),
    .busy      (busy),
    .bs_start  (bs_start),
    .bs_a      (bs_a),
    .bs_reset  (bs_reset),
    .bs_done   (bs_done),
    .bs_found  (bs_found),
    .bs_loc    (bs_loc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int sim_lat  = 3;    // search unit latency in cycles; HANG means never done
  int last_m;          // model of the last granted requester

  logic [7:0] mem [32];

  function automatic bit ref_found(input logic [7:0] k);
    for (int i = 0; i < 32; i++) if (mem[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] ref_loc(input logic [7:0] k);
    for (int i = 0; i < 32; i++) if (mem[i] == k) return 5'(i);
    return 5'd0;
  endfunction

  function automatic int next_grant(input logic [N_REQ-1:0] r, input int last);
    for (int off = 1; off <= int'(N_REQ); off++) begin
      if (r[(last + off) % int'(N_REQ)]) return (last + off) % int'(N_REQ);
    end
    return -1;
  endfunction

  // Behavioural search unit; a miss returns a junk location on purpose.
  int su_cnt;
  always @(posedge clk) begin
    if (reset || bs_reset) begin
      bs_done  <= 1'b0;
      bs_found <= 1'b0;
      bs_loc   <= '0;
      su_cnt   <= 0;
    end else if (bs_start && !bs_done) begin
      if (su_cnt == sim_lat - 1) begin
        bs_done  <= 1'b1;
        bs_found <= ref_found(bs_a);
        bs_loc   <= ref_found(bs_a) ? ref_loc(bs_a) : 5'($urandom_range(1, 31));
      end
      su_cnt <= su_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction from grant to release. Must be entered at a negedge with
  // the arbiter idle (or about to be) and req already driven.
  task automatic txn(input bit hold, input bit poke);
    int          exp_idx;
    int          lat;
    int          cyc;
    bit          seen;
    bit          exp_err;
    logic        exp_found;
    logic [4:0]  exp_loc;
    logic [7:0]  key;
    exp_idx = next_grant(req, last_m);
    check("txn_has_request", 32'(exp_idx >= 0), 32'd1);
    if (exp_idx < 0) return;
    last_m = exp_idx;
    key    = req_a[exp_idx*DATA_W +: DATA_W];
    lat    = sim_lat;
    @(negedge clk);
    check("grant_start", 32'(bs_start), 32'd1);
    check("grant_key", 32'(bs_a), 32'(key));
    check("grant_busy", 32'(busy), 32'd1);
    if (bs_start !== 1'b1) return;
    if (poke) req_a[exp_idx*DATA_W +: DATA_W] = ~key;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 1; i <= int'(TIMEOUT) + 8; i++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        cyc  = i;
        seen = 1'b1;
        break;
      end
      if (poke) check("frozen_key", 32'(bs_a), 32'(key));
    end
    check("resp_seen", 32'(seen), 32'd1);
    if (!seen) return;
    exp_err   = (lat >= int'(TIMEOUT));
    exp_found = exp_err ? 1'b0 : ref_found(key);
    exp_loc   = exp_found ? ref_loc(key) : 5'd0;
    check("resp_valid", 32'(resp_valid), 32'd1 << exp_idx);
    check("resp_found", 32'(resp_found), 32'(exp_found));
    check("resp_loc", 32'(resp_loc), 32'(exp_loc));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_latency", 32'(cyc), 32'(exp_err ? int'(TIMEOUT) : lat + 1));
    check("release_bs_reset", 32'(bs_reset), 32'd1);
    check("release_bs_start", 32'(bs_start), 32'd0);
    check("release_busy", 32'(busy), 32'd1);
    if (poke) req_a[exp_idx*DATA_W +: DATA_W] = key;
    if (!hold) req[exp_idx] = 1'b0;
    @(negedge clk);
    check("idle_bs_reset", 32'(bs_reset), 32'd0);
    check("idle_valid", 32'(resp_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("hold_found", 32'(resp_found), 32'(exp_found));
    check("hold_err", 32'(resp_err), 32'(exp_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_found"}, 32'(resp_found), 32'd0);
    check({tag, "_loc"}, 32'(resp_loc), 32'd0);
    check({tag, "_err"}, 32'(resp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_bs_start"}, 32'(bs_start), 32'd0);
    check({tag, "_bs_a"}, 32'(bs_a), 32'd0);
    check({tag, "_bs_reset"}, 32'(bs_reset), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0]       edge_keys [4];
    logic [N_REQ-1:0] newbits;
    edge_keys = '{8'd15, 8'd0, 8'd62, 8'd255};
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);
    reset  = 1'b1;
    req    = '0;
    req_a  = '0;
    last_m = int'(N_REQ) - 1;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_request_start", 32'(bs_start), 32'd0);

    // Round robin with all requesters held: 0,1,2,3,0
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_a[i*DATA_W +: DATA_W] = 8'(i * 64) + 8'($urandom_range(0, 63));
    end
    req = '1;
    for (int n = 0; n < 5; n++) begin
      sim_lat = $urandom_range(1, 6);
      txn(1'b1, 1'b0);
    end
    req = '0;

    // Single hit on requester 0
    req_a[0 +: DATA_W] = 8'd30;
    req     = 4'b0001;
    sim_lat = 4;
    txn(1'b0, 1'b0);

    // Misses and table edges on requester 1
    for (int i = 0; i < 4; i++) begin
      req_a[1*DATA_W +: DATA_W] = edge_keys[i];
      req     = 4'b0010;
      sim_lat = $urandom_range(1, 6);
      txn(1'b0, 1'b0);
    end

    // Watchdog timeout, then a normal request
    req_a[2*DATA_W +: DATA_W] = 8'd44;
    req     = 4'b0100;
    sim_lat = HANG;
    txn(1'b0, 1'b0);
    req_a[2*DATA_W +: DATA_W] = 8'd20;
    req     = 4'b0100;
    sim_lat = 2;
    txn(1'b0, 1'b0);

    // Done on the final timeout cycle wins; one cycle later the watchdog fires
    req_a[3*DATA_W +: DATA_W] = 8'd14;
    req     = 4'b1000;
    sim_lat = int'(TIMEOUT) - 1;
    txn(1'b0, 1'b0);
    req     = 4'b1000;
    sim_lat = int'(TIMEOUT);
    txn(1'b0, 1'b0);

    // Key changes during a search do not reach bs_a
    req_a[0 +: DATA_W] = 8'd50;
    req     = 4'b0001;
    sim_lat = 6;
    txn(1'b0, 1'b1);

    // Reset in the middle of a search
    req_a[1*DATA_W +: DATA_W] = 8'd40;
    req     = 4'b0010;
    sim_lat = HANG;
    @(negedge clk);
    check("midrun_grant", 32'(bs_start), 32'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("midrun_reset");
    req = 4'b1000;
    req_a[3*DATA_W +: DATA_W] = 8'($urandom_range(0, 255));
    last_m  = int'(N_REQ) - 1;
    sim_lat = 3;
    @(negedge clk);
    reset = 1'b0;
    txn(1'b0, 1'b0);
    req = 4'b0011;
    txn(1'b0, 1'b0);
    txn(1'b0, 1'b0);

    // Random traffic; each requester drops its request when served
    for (int n = 0; n < 24; n++) begin
      newbits = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      if ((req | newbits) == '0) newbits[$urandom_range(0, N_REQ - 1)] = 1'b1;
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (newbits[i] && !req[i]) begin
          req_a[i*DATA_W +: DATA_W] = $urandom_range(0, 1) ?
              8'(2 * $urandom_range(0, 31)) : 8'($urandom_range(0, 255));
        end
      end
      req     = req | newbits;
      sim_lat = $urandom_range(1, 6);
      txn(1'b0, 1'b0);
    end
    for (int n = 0; n < int'(N_REQ) && req != '0; n++) begin
      sim_lat = $urandom_range(1, 6);
      txn(1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
